count_checker: RTL and testbench
================================

# count_checker

Downstream consumer of the 3-bit free-running counter. Samples the counter value every clock, checks that it moves only by legal steps (hold, +1 mod 2^WIDTH, or restart to 0), and counts full wraps and illegal jumps. Provides a lock indication and sticky error flag for the status path. Purely synchronous to the counter's clock; no CDC inside.

## Interface
- WIDTH, 3: width of the monitored count.
- WRAP_W, 8: width of the wrap counter.
- ERR_W, 4: width of the error counter.

- clk  in  1  rising-edge clock, same clock as the upstream counter.
- res  in  1  asynchronous, active-low reset; all state cleared while low.
- en  in  1  monitor enable; when low the block idles and counters hold.
- clr  in  1  synchronous clear of counters and sticky flag.
- count_in  in  WIDTH  counter value under observation.
- locked  out  1  high while in TRACK.
- wrap_pulse  out  1  one-cycle pulse on each max→0 step.
- restart_pulse  out  1  one-cycle pulse on a legal jump to 0 from a value other than max.
- err_pulse  out  1  one-cycle pulse on an illegal step.
- err_sticky  out  1  set on any illegal step, cleared only by res or clr.
- wrap_cnt  out  WRAP_W  number of wraps, modulo 2^WRAP_W.
- err_cnt  out  ERR_W  number of illegal steps, saturating at all-ones.

## Operation
- Internal prev register (WIDTH) holds the last accepted sample.
- States: IDLE, TRACK, RESYNC (encoding 2'b00, 2'b01, 2'b10).
- IDLE: en=0 → stay. en=1 → prev←count_in, no check, go TRACK.
- RESYNC: entered after an illegal step. en=1 → prev←count_in, no check, go TRACK. en=0 → IDLE.
- TRACK, en=1, classify count_in against prev:
  - equal → hold, no pulse.
  - prev+1 mod 2^WIDTH, prev≠max → advance, no pulse.
  - prev=max and count_in=0 → wrap_pulse, wrap_cnt+1 (wraps).
  - count_in=0 and prev≠max and prev≠0 → restart_pulse, no error.
  - anything else → err_pulse, err_sticky←1, err_cnt+1 (saturate), go RESYNC.
  - prev←count_in in every TRACK case.
- TRACK, en=0 → IDLE; prev, counters, sticky hold.
- clr=1: wrap_cnt←0, err_cnt←0, err_sticky←0, pulses 0; state → RESYNC if en=1 else IDLE. clr overrides any classification in the same cycle.
- locked = (state==TRACK); outputs all registered.

## Timing
- Reset values: state IDLE, prev 0, locked 0, all pulses 0, err_sticky 0, wrap_cnt 0, err_cnt 0.
- Latency 1: count_in sampled at edge k → pulses/counters/sticky valid after edge k, pulses low after edge k+1 unless re-triggered.
- First enabled edge after IDLE/RESYNC never produces a pulse; locked rises after that edge.
- err_cnt at all-ones stays there; err_pulse and err_sticky still fire.
- wrap_cnt at all-ones + wrap → 0, no flag.
- res asserted mid-operation clears immediately regardless of clk; deassertion synchronised externally.

## Structure
- Package count_chk_pkg: state encoding constants (ST_IDLE, ST_TRACK, ST_RESYNC), state width.
- One sub-module event_counter (parameters W, SAT): increment, sync clear, wrap or saturate; instantiated for wrap_cnt (SAT=0) and err_cnt (SAT=1).
- Top holds FSM, prev register, classifier, pulse registers.

## Test plan
- Reset: res=0 with count_in toggling → all outputs 0, state IDLE; release, en=0 for 5 cycles → outputs unchanged.
- Clean run: en=1, count_in 0,1,…,7,0,1,…,7,0 (17 edges) → locked=1 after edge 1, wrap_pulse on the two 7→0 edges, wrap_cnt=2, err_cnt=0.
- Hold and restart: 3,3,4,0,1 → no pulse on 3→3 or 3→4, restart_pulse on 4→0, no error.
- Illegal jump: 2,5,6,7 → err_pulse on 2→5, err_sticky=1, err_cnt=1, locked=0 for one cycle (RESYNC), 5 re-captured, locked=1, 6,7 clean.
- Saturation: 20 illegal jumps with ERR_W=4 → err_cnt stops at 15; wrap_cnt with 256 wraps → returns to 0.
- clr and reset mid-stream: clr=1 coincident with 7→0 → no wrap_pulse, counters 0, state RESYNC; res low mid-TRACK → immediate return to reset values.

Source files
------------

// File: rtl/count_chk_pkg.sv
// Shared definitions for the counter step checker: FSM state encoding and width.
package count_chk_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'b00,
    ST_TRACK  = 2'b01,
    ST_RESYNC = 2'b10
  } state_e;

endpackage

// File: rtl/event_counter.sv
// Event counter with synchronous clear; wraps modulo 2^W or saturates at all-ones.
module event_counter #(
  parameter int unsigned W   = 4,
  parameter bit          SAT = 1'b0
) (
  input  logic         clk,
  input  logic         res,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_max;

  assign at_max = (cnt_q == {W{1'b1}});

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !(SAT && at_max)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/count_checker.sv
// Monitors a free-running counter for legal steps (hold, +1, wrap, restart to 0),
// counting wraps and illegal jumps and flagging errors for the status path.
module count_checker
  import count_chk_pkg::*;
#(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned WRAP_W = 8,
  parameter int unsigned ERR_W  = 4
) (
  input  logic              clk,
  input  logic              res,
  input  logic              en,
  input  logic              clr,
  input  logic [WIDTH-1:0]  count_in,
  output logic              locked,
  output logic              wrap_pulse,
  output logic              restart_pulse,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam logic [WIDTH-1:0] MaxVal = {WIDTH{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] prev_inc;
  logic             wrap_q, wrap_d;
  logic             restart_q, restart_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic             prev_is_max;

  assign prev_inc    = prev_q + WIDTH'(1);
  assign prev_is_max = (prev_q == MaxVal);

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    wrap_d    = 1'b0;
    restart_d = 1'b0;
    err_d     = 1'b0;
    sticky_d  = sticky_q;
    if (clr) begin
      // Clear wins over classification; re-lock via RESYNC so no pulse on the next edge.
      sticky_d = 1'b0;
      state_d  = en ? ST_RESYNC : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_RESYNC: begin
          if (en) begin
            prev_d  = count_in;
            state_d = ST_TRACK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_TRACK: begin
          if (!en) begin
            state_d = ST_IDLE;
          end else begin
            prev_d = count_in;
            if (count_in == prev_q) begin
              state_d = ST_TRACK;
            end else if (!prev_is_max && (count_in == prev_inc)) begin
              state_d = ST_TRACK;
            end else if (prev_is_max && (count_in == '0)) begin
              wrap_d = 1'b1;
            end else if ((count_in == '0) && (prev_q != '0)) begin
              restart_d = 1'b1;
            end else begin
              err_d    = 1'b1;
              sticky_d = 1'b1;
              state_d  = ST_RESYNC;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      wrap_q    <= 1'b0;
      restart_q <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      wrap_q    <= wrap_d;
      restart_q <= restart_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
    end
  end

  event_counter #(
    .W  (WRAP_W),
    .SAT(1'b0)
  ) u_wrap_cnt (
    .clk(clk),
    .res(res),
    .clr(clr),
    .inc(wrap_d),
    .cnt(wrap_cnt)
  );

  event_counter #(
    .W  (ERR_W),
    .SAT(1'b1)
  ) u_err_cnt (
    .clk(clk),
    .res(res),
    .clr(clr),
    .inc(err_d),
    .cnt(err_cnt)
  );

  assign locked        = (state_q == ST_TRACK);
  assign wrap_pulse    = wrap_q;
  assign restart_pulse = restart_q;
  assign err_pulse     = err_q;
  assign err_sticky    = sticky_q;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: table of per-edge vectors plus multi-cycle corner sequences.
module tb_count_checker;

  logic       clk = 1'b0;
  logic       res;
  logic       en;
  logic       clr;
  logic [2:0] count_in;
  logic       locked, wrap_pulse, restart_pulse, err_pulse, err_sticky;
  logic [7:0] wrap_cnt;
  logic [3:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic       clr;
    logic [2:0] cnt;
    logic       lk;
    logic       wp;
    logic       rp;
    logic       ep;
    logic       st;
    logic [7:0] wc;
    logic [3:0] ec;
  } vec_t;

  vec_t vecs[$];

  count_checker #(
    .WIDTH (3),
    .WRAP_W(8),
    .ERR_W (4)
  ) dut (
    .clk          (clk),
    .res          (res),
    .en           (en),
    .clr          (clr),
    .count_in     (count_in),
    .locked       (locked),
    .wrap_pulse   (wrap_pulse),
    .restart_pulse(restart_pulse),
    .err_pulse    (err_pulse),
    .err_sticky   (err_sticky),
    .wrap_cnt     (wrap_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input int lk, input int wp, input int rp, input int ep,
                         input int st, input int wc, input int ec);
    chk("locked", idx, int'(locked), lk);
    chk("wrap_pulse", idx, int'(wrap_pulse), wp);
    chk("restart_pulse", idx, int'(restart_pulse), rp);
    chk("err_pulse", idx, int'(err_pulse), ep);
    chk("err_sticky", idx, int'(err_sticky), st);
    chk("wrap_cnt", idx, int'(wrap_cnt), wc);
    chk("err_cnt", idx, int'(err_cnt), ec);
  endtask

  task automatic add(input int e, input int c, input int cnt, input int lk, input int wp,
                     input int rp, input int ep, input int st, input int wc, input int ec);
    vec_t v;
    v.en  = e[0];
    v.clr = c[0];
    v.cnt = cnt[2:0];
    v.lk  = lk[0];
    v.wp  = wp[0];
    v.rp  = rp[0];
    v.ep  = ep[0];
    v.st  = st[0];
    v.wc  = wc[7:0];
    v.ec  = ec[3:0];
    vecs.push_back(v);
  endtask

  task automatic edge_step(input logic e, input logic c, input logic [2:0] cnt);
    en       = e;
    clr      = c;
    count_in = cnt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    res      = 1'b0;
    en       = 1'b1;
    clr      = 1'b0;
    count_in = '0;

    // Reset held with activity on the inputs.
    for (int i = 0; i < 4; i++) begin
      count_in = 3'(i * 3);
      @(posedge clk);
      #1;
      chk_all(100 + i, 0, 0, 0, 0, 0, 0, 0);
    end
    en  = 1'b0;
    res = 1'b1;

    // Idle with en=0.
    for (int i = 0; i < 5; i++) add(0, 0, i, 0, 0, 0, 0, 0, 0, 0);
    // Clean run: 0..7,0..7,0.
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 8; i++) add(1, 0, i, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    for (int i = 1; i < 8; i++) add(1, 0, i, 1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 1, 1, 0, 0, 0, 2, 0);
    // Hold and restart: 1,2,3,3,4,0,1.
    for (int i = 1; i < 4; i++) add(1, 0, i, 1, 0, 0, 0, 0, 2, 0);
    add(1, 0, 3, 1, 0, 0, 0, 0, 2, 0);
    add(1, 0, 4, 1, 0, 0, 0, 0, 2, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 2, 0);
    add(1, 0, 1, 1, 0, 0, 0, 0, 2, 0);
    // Illegal jump 2->5, RESYNC recaptures 5, then 6,7 clean.
    add(1, 0, 2, 1, 0, 0, 0, 0, 2, 0);
    add(1, 0, 5, 0, 0, 0, 1, 1, 2, 1);
    add(1, 0, 5, 1, 0, 0, 0, 1, 2, 1);
    add(1, 0, 6, 1, 0, 0, 0, 1, 2, 1);
    add(1, 0, 7, 1, 0, 0, 0, 1, 2, 1);
    // Drop en, re-enter from IDLE on an arbitrary value.
    add(0, 0, 3, 0, 0, 0, 0, 1, 2, 1);
    add(1, 0, 3, 1, 0, 0, 0, 1, 2, 1);
    for (int i = 4; i < 8; i++) add(1, 0, i, 1, 0, 0, 0, 1, 2, 1);
    // clr on the 7->0 step: no wrap, counters cleared, RESYNC.
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 2, 1, 0, 0, 0, 0, 0, 0);
    // clr with en=0 goes to IDLE; next enabled edge captures without checking.
    add(0, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 7, 1, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      edge_step(vecs[i].en, vecs[i].clr, vecs[i].cnt);
      chk_all(i, vecs[i].lk, vecs[i].wp, vecs[i].rp, vecs[i].ep, vecs[i].st, vecs[i].wc,
              vecs[i].ec);
    end

    // 256 wraps return wrap_cnt to 0.
    edge_step(1'b1, 1'b1, 3'd0);
    edge_step(1'b1, 1'b0, 3'd0);
    chk("wrap_start_locked", 0, int'(locked), 1);
    for (int w = 1; w <= 256; w++) begin
      for (int s = 1; s < 8; s++) edge_step(1'b1, 1'b0, 3'(s));
      edge_step(1'b1, 1'b0, 3'd0);
      if (w == 255) chk("wrap_cnt_255", w, int'(wrap_cnt), 255);
      if (w == 256) begin
        chk("wrap_cnt_256", w, int'(wrap_cnt), 0);
        chk("wrap_pulse_256", w, int'(wrap_pulse), 1);
        chk("err_cnt_wraps", w, int'(err_cnt), 0);
      end
    end

    // 20 illegal jumps: err_cnt saturates at 15, pulses and sticky keep firing.
    for (int i = 1; i <= 20; i++) begin
      edge_step(1'b1, 1'b0, 3'd5);
      chk("sat_err_pulse", i, int'(err_pulse), 1);
      chk("sat_err_cnt", i, int'(err_cnt), (i < 15) ? i : 15);
      chk("sat_locked", i, int'(locked), 0);
      edge_step(1'b1, 1'b0, 3'd2);
      chk("sat_relock", i, int'(locked), 1);
      chk("sat_pulse_low", i, int'(err_pulse), 0);
    end
    chk("sat_sticky", 0, int'(err_sticky), 1);

    // Asynchronous reset mid-TRACK, away from any clock edge.
    #2;
    res = 1'b0;
    #1;
    chk_all(200, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all(201, 0, 0, 0, 0, 0, 0, 0);
    res = 1'b1;
    edge_step(1'b1, 1'b0, 3'd4);
    chk_all(202, 1, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
